// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory access controller:
// size codes, FSM encoding and the alignment rule.
package dmem_ctrl_pkg;

  localparam int LINE_W = 64;
  localparam int IDX_W  = 11;
  localparam int ADDR_W = IDX_W + 3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RESP
  } state_t;

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [2:0] off
  );
    logic m;
    m = 1'b0;
    unique case (sz)
      SZ_H:    m = off[0];
      SZ_W:    m = |off[1:0];
      SZ_D:    m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// CPU request/response, debugger write and memory
// port bundle for the data-memory access controller.
interface dmem_access_ctrl_if;
  import dmem_ctrl_pkg::*;

  logic              cpu_req_valid_i;
  logic              cpu_req_ready_o;
  logic [ADDR_W-1:0] cpu_req_addr_i;
  logic              cpu_req_we_i;
  logic [1:0]        cpu_req_size_i;
  logic              cpu_req_signed_i;
  logic [LINE_W-1:0] cpu_req_wdata_i;
  logic              cpu_resp_valid_o;
  logic              cpu_resp_err_o;
  logic [LINE_W-1:0] cpu_resp_rdata_o;

  logic              dbg_write_i;
  logic [IDX_W-1:0]  dbg_addr_i;
  logic [LINE_W-1:0] dbg_data_i;
  logic              dbg_ack_o;

  logic [IDX_W-1:0]  mem_addr_o;
  logic              mem_we_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;

  modport slave (
    input  cpu_req_valid_i, cpu_req_addr_i,
    input  cpu_req_we_i, cpu_req_size_i,
    input  cpu_req_signed_i, cpu_req_wdata_i,
    output cpu_req_ready_o, cpu_resp_valid_o,
    output cpu_resp_err_o, cpu_resp_rdata_o,
    input  dbg_write_i, dbg_addr_i, dbg_data_i,
    output dbg_ack_o,
    output mem_addr_o, mem_we_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output cpu_req_valid_i, cpu_req_addr_i,
    output cpu_req_we_i, cpu_req_size_i,
    output cpu_req_signed_i, cpu_req_wdata_i,
    input  cpu_req_ready_o, cpu_resp_valid_o,
    input  cpu_resp_err_o, cpu_resp_rdata_o,
    output dbg_write_i, dbg_addr_i, dbg_data_i,
    input  dbg_ack_o,
    input  mem_addr_o, mem_we_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment: store mask/merge and
// load extract with sign/zero extension.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [2:0]        off_i,
  input  logic              sgn_i,
  input  logic [LINE_W-1:0] rdata_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] merge_o,
  output logic [LINE_W-1:0] load_o
);

  logic [5:0]        sh;
  logic [LINE_W-1:0] base;
  logic [LINE_W-1:0] mask;
  logic [LINE_W-1:0] lane;

  always_comb begin
    sh = {off_i, 3'b000};
    unique case (size_i)
      SZ_B:    base = 64'h0000_0000_0000_00FF;
      SZ_H:    base = 64'h0000_0000_0000_FFFF;
      SZ_W:    base = 64'h0000_0000_FFFF_FFFF;
      default: base = '1;
    endcase
    mask    = base << sh;
    merge_o = (rdata_i & ~mask) | ((wdata_i << sh) & mask);
    lane    = rdata_i >> sh;
    unique case (size_i)
      SZ_B:    load_o = {{56{sgn_i & lane[7]}}, lane[7:0]};
      SZ_H:    load_o = {{48{sgn_i & lane[15]}}, lane[15:0]};
      SZ_W:    load_o = {{32{sgn_i & lane[31]}}, lane[31:0]};
      default: load_o = lane;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer for the 64-bit data memory with
// sub-dword RMW and a priority debugger write port.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clk_en,
  dmem_access_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  line_q;
  logic [2:0]        off_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic              err_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] data_q, data_d;

  logic              idle;
  logic              dbg_go;
  logic              accept;
  logic              req_err;
  logic [IDX_W-1:0]  req_line;
  logic [2:0]        req_off;
  logic [LINE_W-1:0] merge;
  logic [LINE_W-1:0] load;

  dmem_lane_align u_align (
    .size_i  (size_q),
    .off_i   (off_q),
    .sgn_i   (sgn_q),
    .rdata_i (bus.mem_rdata_i),
    .wdata_i (wdata_q),
    .merge_o (merge),
    .load_o  (load)
  );

  assign req_line = bus.cpu_req_addr_i[ADDR_W-1:3];
  assign req_off  = bus.cpu_req_addr_i[2:0];
  assign req_err  = misaligned(bus.cpu_req_size_i, req_off);

  always_comb begin
    idle   = (state_q == S_IDLE);
    dbg_go = idle & bus.dbg_write_i & clk_en;
    bus.cpu_req_ready_o = idle & ~bus.dbg_write_i & clk_en;
    accept = bus.cpu_req_valid_i & bus.cpu_req_ready_o;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d = '0;
          if (req_err) begin
            state_d = S_RESP;
          end else if (bus.cpu_req_we_i &&
                       bus.cpu_req_size_i == SZ_D) begin
            state_d = S_WR;
            data_d  = bus.cpu_req_wdata_i;
          end else begin
            state_d = S_RD;
          end
        end
      end
      // stores already issued the line address at accept,
      // so read data is available here for the merge
      S_RD: begin
        if (we_q) begin
          data_d  = merge;
          state_d = S_WR;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        data_d  = load;
        state_d = S_RESP;
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      data_q  <= data_d;
      if (accept) begin
        line_q  <= req_line;
        off_q   <= req_off;
        we_q    <= bus.cpu_req_we_i;
        size_q  <= bus.cpu_req_size_i;
        sgn_q   <= bus.cpu_req_signed_i;
        err_q   <= req_err;
        wdata_q <= bus.cpu_req_wdata_i;
      end
    end
  end

  always_comb begin
    bus.dbg_ack_o = dbg_go;
    bus.mem_we_o  = clk_en & (dbg_go | (state_q == S_WR));
    bus.mem_addr_o = dbg_go ? bus.dbg_addr_i :
                     accept ? req_line : line_q;
    bus.mem_wdata_o = '0;
    if (dbg_go) begin
      bus.mem_wdata_o = bus.dbg_data_i;
    end else if (state_q == S_WR) begin
      bus.mem_wdata_o = data_q;
    end
    bus.cpu_resp_valid_o = clk_en & (state_q == S_RESP);
    bus.cpu_resp_err_o   = bus.cpu_resp_valid_o & err_q;
    bus.cpu_resp_rdata_o = '0;
    if (bus.cpu_resp_valid_o && !err_q && !we_q) begin
      bus.cpu_resp_rdata_o = data_q;
    end
  end

endmodule
